div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit radix-2 divider for the E stage of the MIPS pipeline, executing DIV and DIVU. It produces `E_div_stall`, which the hazard unit folds into `longest_stall` to freeze F through M while the divide runs. It consumes the E-stage enable and flush from the hazard unit, so it can hold a finished result across unrelated stalls and abandon work on an exception or branch flush.

## Interface
Parameters:
- none (width fixed at 32).

Ports:
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `E_div_req` in 1: E-stage instruction is DIV or DIVU.
- `E_div_signed` in 1: 1 = DIV, 0 = DIVU; sampled with the request.
- `E_src_a` in 32: dividend (rs).
- `E_src_b` in 32: divisor (rt).
- `E_ena` in 1: E pipeline register enable from the hazard unit; 1 = instruction leaves E this edge.
- `E_flush` in 1: E-stage flush (exception or branch taken).
- `E_div_stall` out 1: divide in progress; hold pipeline.
- `E_div_lo` out 32: quotient.
- `E_div_hi` out 32: remainder.

## Operation
- States: IDLE, BUSY, DONE. A 6-bit iteration counter is used.
- IDLE, with `E_div_req`=1 and `E_flush`=0:
  - Latch |a| and |b| (absolute values only when signed; raw values when unsigned).
  - Latch the quotient sign (sign a XOR sign b, signed only) and the remainder sign (sign a, signed only).
  - Clear the partial remainder and the counter, then go to BUSY.
- BUSY, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the 33-bit partial remainder.
  - If non-negative, keep the difference and set the quotient LSB.
  - After the 32nd step, apply sign fixup (two's-complement negate where the latched sign is 1).
  - Write `E_div_lo` and `E_div_hi`, then go to DONE.
- DONE:
  - Result is valid and stall is low.
  - Stay in DONE while `E_ena`=0, so the frozen E instruction does not restart.
  - Go to IDLE when `E_ena`=1 or `E_flush`=1.
- `E_flush`=1 in any state: next state is IDLE, and partial work is discarded. `E_div_lo` and `E_div_hi` keep their previous values.
- `E_div_stall` is combinational:
  - 1 when (IDLE and `E_div_req` and not `E_flush`) or (BUSY and not `E_flush`).
  - 0 otherwise.
- Divide by zero, both modes: quotient 0xFFFFFFFF, remainder = `E_src_a` unmodified. Sign fixup is bypassed and the normal latency is kept.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps, no trap).
- Remainder sign always follows the dividend. A zero result is never negated to a nonzero value.

## Timing
- Reset values: state IDLE, counter 0, `E_div_stall` 0, `E_div_lo` 0, `E_div_hi` 0.
- Reset asserted mid-BUSY: immediate return to IDLE. Stall drops asynchronously and the outputs clear to 0.
- Latency:
  - Request cycle (stall=1), then 32 BUSY cycles (stall=1), then DONE (stall=0).
  - `E_div_stall` is high for exactly 33 consecutive cycles.
  - The result is visible in the first cycle with stall=0.
- Back-to-back divides: the DONE→IDLE edge occurs with `E_ena`=1. The next divide, now in E, is accepted in the following cycle. There is no lost or duplicated request.
- Stalls from i/d caches during DONE: the unit holds DONE, and results and stall stay stable for any number of cycles.
- Operands change during BUSY: no effect, because only latched copies are used.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In the request cycle, if divisor = 0, or |a| < |b|, or a = 0, the unit goes straight from IDLE to DONE.
  - Stall is high for 1 cycle only.
  - Result values are identical to the full path: quotient 0 and remainder a (or the divide-by-zero values).
- `DIV_EARLY_OUT_EN` undefined: every divide takes the fixed 33-cycle stall.

## Test plan
- DIVU 100 / 7 with `E_ena` following `~E_div_stall` → stall high 33 cycles; lo=0x0000000E, hi=0x00000002.
- DIV 0xFFFFFF9C (-100) / 7 → lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2). Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5. Stall is 33 cycles without the macro and 1 cycle with `DIV_EARLY_OUT_EN`.
- Assert `E_flush` at BUSY cycle 10 → stall low that same cycle; IDLE next; lo/hi unchanged from the prior result. A new request 1 cycle later completes normally.
- Hold `E_ena`=0 for 20 cycles after completion with `E_div_req` still 1 → unit stays in DONE, stall stays 0, no restart. Raising `E_ena` returns the unit to IDLE.
- Deassert `resetn` at BUSY cycle 16 → stall, lo and hi read 0 immediately. After release, DIVU 9 / 3 gives lo=3, hi=0.

Source files
------------

// File: rtl/div_unit_if.sv
// E-stage divider handshake: request/operands from the pipeline, stall and
// quotient/remainder back to it.
interface div_if;
  logic        E_div_req;
  logic        E_div_signed;
  logic [31:0] E_src_a;
  logic [31:0] E_src_b;
  logic        E_ena;
  logic        E_flush;
  logic        E_div_stall;
  logic [31:0] E_div_lo;
  logic [31:0] E_div_hi;

  modport master (
    output E_div_req, E_div_signed, E_src_a, E_src_b, E_ena, E_flush,
    input  E_div_stall, E_div_lo, E_div_hi
  );

  modport slave (
    input  E_div_req, E_div_signed, E_src_a, E_src_b, E_ena, E_flush,
    output E_div_stall, E_div_lo, E_div_hi
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU) for the E stage.
// Optional DIV_EARLY_OUT_EN: trivial divides finish in the request cycle.
module div_unit (
  input logic  clk,
  input logic  resetn,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic        dvz_q, dvz_d;

  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] rem_step, quo_step, lo_fix, hi_fix;

  always_comb begin
    a_neg = bus.E_div_signed & bus.E_src_a[31];
    b_neg = bus.E_div_signed & bus.E_src_b[31];
    a_abs = a_neg ? (~bus.E_src_a + 32'd1) : bus.E_src_a;
    b_abs = b_neg ? (~bus.E_src_b + 32'd1) : bus.E_src_b;

    // One restoring step on {rem, quo}; rem always stays below the divisor.
    sh       = {rem_q, quo_q[31]};
    ge       = (sh >= {1'b0, dvs_q});
    rem_step = ge ? 32'(sh - {1'b0, dvs_q}) : sh[31:0];
    quo_step = {quo_q[30:0], ge};

    // Negating zero yields zero, so a zero result never turns nonzero.
    lo_fix = dvz_q ? 32'hFFFF_FFFF : (qsign_q ? (~quo_step + 32'd1) : quo_step);
    hi_fix = rsign_q ? (~rem_step + 32'd1) : rem_step;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    dvz_d   = dvz_q;
    case (state_q)
      IDLE: if (bus.E_div_req) begin
        quo_d   = a_abs;
        dvs_d   = b_abs;
        rem_d   = '0;
        cnt_d   = '0;
        qsign_d = a_neg ^ b_neg;
        rsign_d = a_neg;
        dvz_d   = (bus.E_src_b == 32'd0);
        state_d = BUSY;
`ifdef DIV_EARLY_OUT_EN
        if (bus.E_src_b == 32'd0 || a_abs < b_abs || bus.E_src_a == 32'd0) begin
          lo_d    = (bus.E_src_b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
          hi_d    = bus.E_src_a;
          state_d = DONE;
        end
`endif
      end
      BUSY: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          lo_d    = lo_fix;
          hi_d    = hi_fix;
          state_d = DONE;
        end
      end
      DONE: if (bus.E_ena) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush abandons work in any state and leaves the last result intact.
    if (bus.E_flush) begin
      state_d = IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dvz_q   <= dvz_d;
    end
  end

  // Gated by reset so the pipeline unfreezes the moment reset asserts.
  assign bus.E_div_stall = resetn & ~bus.E_flush &
                           ((state_q == IDLE & bus.E_div_req) | (state_q == BUSY));
  assign bus.E_div_lo = lo_q;
  assign bus.E_div_hi = hi_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, flush, DONE hold, back-to-back and mid-divide reset.
module tb_div_unit;
  localparam int LONG = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int SHORT = 1;
`else
  localparam int SHORT = 33;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_if bus();
  logic ena_follow = 1'b1;
  logic ena_man = 1'b0;
  assign bus.E_ena = ena_follow ? ~bus.E_div_stall : ena_man;

  div_unit dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_lo = 32'd0;
  logic [31:0] last_hi = 32'd0;

  task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input int ecyc, input bit keep_req);
    int cyc;
    @(posedge clk); #1;
    bus.E_div_req = 1'b1; bus.E_div_signed = sg; bus.E_src_a = a; bus.E_src_b = b;
    #1;
    cyc = 0;
    while (bus.E_div_stall === 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
      bus.E_src_a = $urandom; bus.E_src_b = $urandom;
      #1;
    end
    n_cmp++;
    if (cyc !== ecyc) begin
      n_bad++; $display("FAIL %s.stall_cycles: got %0d want %0d", name, cyc, ecyc);
    end
    n_cmp++;
    if (bus.E_div_lo !== elo) begin
      n_bad++; $display("FAIL %s.lo: got %h want %h", name, bus.E_div_lo, elo);
    end
    n_cmp++;
    if (bus.E_div_hi !== ehi) begin
      n_bad++; $display("FAIL %s.hi: got %h want %h", name, bus.E_div_hi, ehi);
    end
    last_lo = elo; last_hi = ehi;
    if (!keep_req) begin
      @(posedge clk); #1;
      bus.E_div_req = 1'b0;
    end
  endtask

  task automatic test_reset;
    bus.E_div_req = 1'b0; bus.E_div_signed = 1'b0;
    bus.E_src_a = '0; bus.E_src_b = '0; bus.E_flush = 1'b0;
    resetn = 1'b0;
    #12;
    n_cmp++;
    if (bus.E_div_stall !== 1'b0) begin
      n_bad++; $display("FAIL reset.stall: got %b want 0", bus.E_div_stall);
    end
    n_cmp++;
    if (bus.E_div_lo !== 32'd0 || bus.E_div_hi !== 32'd0) begin
      n_bad++; $display("FAIL reset.lohi: got %h/%h want 0/0", bus.E_div_lo, bus.E_div_hi);
    end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_divu;
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, LONG, 1'b0);
    run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, LONG, 1'b0);
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, SHORT, 1'b0);
  endtask

  task automatic test_div_signed;
    run_div("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, LONG, 1'b0);
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, LONG, 1'b0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, LONG, 1'b0);
    run_div("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, LONG, 1'b0);
    run_div("div_0_m5", 1'b1, 32'd0, 32'hFFFFFFFB, 32'd0, 32'd0, SHORT, 1'b0);
  endtask

  task automatic test_div_zero;
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, SHORT, 1'b0);
    run_div("div_m7_0", 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, SHORT, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_div("b2b_first", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, LONG, 1'b1);
    run_div("b2b_second", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LONG, 1'b0);
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    bus.E_div_req = 1'b1; bus.E_div_signed = 1'b0; bus.E_src_a = 32'd1000; bus.E_src_b = 32'd10;
    repeat (10) @(posedge clk);
    #1; bus.E_flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.E_div_stall !== 1'b0) begin
      n_bad++; $display("FAIL flush.stall_same_cycle: got %b want 0", bus.E_div_stall);
    end
    @(posedge clk); #1;
    bus.E_flush = 1'b0; bus.E_div_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.E_div_stall !== 1'b0) begin
      n_bad++; $display("FAIL flush.stall_after: got %b want 0", bus.E_div_stall);
    end
    n_cmp++;
    if (bus.E_div_lo !== last_lo || bus.E_div_hi !== last_hi) begin
      n_bad++; $display("FAIL flush.lohi_kept: got %h/%h want %h/%h",
                        bus.E_div_lo, bus.E_div_hi, last_lo, last_hi);
    end
    run_div("flush_retry", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, LONG, 1'b0);
  endtask

  task automatic test_hold_done;
    int cyc;
    ena_follow = 1'b0; ena_man = 1'b0;
    run_div("hold_50_6", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, LONG, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      n_cmp++;
      if (bus.E_div_stall !== 1'b0 || bus.E_div_lo !== 32'd8 || bus.E_div_hi !== 32'd2) begin
        n_bad++; $display("FAIL hold.cycle%0d: got stall=%b lo=%h hi=%h want 0/8/2",
                          i, bus.E_div_stall, bus.E_div_lo, bus.E_div_hi);
      end
    end
    ena_man = 1'b1;
    @(posedge clk); #1;
    ena_follow = 1'b1;
    bus.E_src_a = 32'd9; bus.E_src_b = 32'd3;
    #1;
    n_cmp++;
    if (bus.E_div_stall !== 1'b1) begin
      n_bad++; $display("FAIL hold.back_to_idle: got stall=%b want 1", bus.E_div_stall);
    end
    cyc = 1;
    while (bus.E_div_stall === 1'b1 && cyc < 200) begin
      @(posedge clk); #2;
      if (bus.E_div_stall === 1'b1) cyc++;
    end
    n_cmp++;
    if (cyc !== LONG || bus.E_div_lo !== 32'd3 || bus.E_div_hi !== 32'd0) begin
      n_bad++; $display("FAIL hold.next_div: got cyc=%0d lo=%h hi=%h want %0d/3/0",
                        cyc, bus.E_div_lo, bus.E_div_hi, LONG);
    end
    @(posedge clk); #1;
    bus.E_div_req = 1'b0;
  endtask

  task automatic test_reset_busy;
    @(posedge clk); #1;
    bus.E_div_req = 1'b1; bus.E_div_signed = 1'b0; bus.E_src_a = 32'd100; bus.E_src_b = 32'd7;
    repeat (16) @(posedge clk);
    #1; resetn = 1'b0;
    #1;
    n_cmp++;
    if (bus.E_div_stall !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy.stall: got %b want 0", bus.E_div_stall);
    end
    n_cmp++;
    if (bus.E_div_lo !== 32'd0 || bus.E_div_hi !== 32'd0) begin
      n_bad++; $display("FAIL rst_busy.lohi: got %h/%h want 0/0", bus.E_div_lo, bus.E_div_hi);
    end
    bus.E_div_req = 1'b0;
    @(negedge clk); resetn = 1'b1;
    run_div("rst_after_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LONG, 1'b0);
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_hold_done();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
